// File: rtl/iram_arb_pkg.sv
// Shared types and constants for the internal-RAM arbiter.
package iram_arb_pkg;

  // Arbiter phases: normal CPU-priority operation, one cycle of CPU hold
  // while the in-flight CPU access completes, then one forced DMA slot.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_REQ = 2'd1,
    HOLD_GNT = 2'd2
  } arb_state_e;

  localparam int          IRAM_SIZE      = 128;
  localparam logic [15:0] RAMCR_ADDR     = 16'h0014;
  localparam int          RAMCR_RAME_BIT = 6;
  localparam int          RAMCR_STBY_BIT = 7;

endpackage

// File: rtl/iram_arbiter.sv
// Internal RAM arbiter: shares a single-port 128x8 RAM between the cpu01 bus
// (default priority, zero added latency) and a DMA/debug requester.
// A DMA request blocked for MAX_WAIT consecutive cycles holds the CPU for two
// cycles and takes one RAM slot.
// Optional build macro: IRAM_RAMCR_EN adds the RAM control register (RAME/STBY)
// at CPU address 0x0014; without it RAME is constant 1 and 0x0014 is not claimed.
//
// DMA handshake: dma_req is a level request whose rw/addr/wdata stay stable
// until dma_ack. dma_ack is a one-cycle registered pulse marking completion;
// dma_rdata is valid while dma_ack = 1. A request still high in the ack cycle
// is a new transfer, so back-to-back transfers run one per cycle.
module iram_arbiter
  import iram_arb_pkg::*;
#(
  parameter int          AW        = 7,
  parameter int          DW        = 8,
  parameter int          MAX_WAIT  = 8,
  parameter logic [15:0] IRAM_BASE = 16'h0080
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_vma,
  input  logic          cpu_rw,
  input  logic [15:0]   cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_sel,
  output logic          cpu_hold,
  input  logic          dma_req,
  input  logic          dma_rw,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);
  localparam logic [16:0] WIN_LO    = {1'b0, IRAM_BASE};
  localparam logic [16:0] WIN_HI    = WIN_LO + 17'(IRAM_SIZE);

  arb_state_e    state_q, state_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          dma_ack_q, dma_ack_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;

  logic          rame;
  logic          ramcr_rd;
  logic          cpu_in_win;
  logic          cpu_hit;
  logic          dma_own;
  logic          dma_port;

  // CPU address decode; the 17-bit compare keeps the upper window bound
  // from wrapping when the window sits at the top of the address map.
  assign cpu_in_win = ({1'b0, cpu_addr} >= WIN_LO) && ({1'b0, cpu_addr} < WIN_HI);
  assign cpu_hit    = cpu_vma & cpu_in_win & rame;
  assign cpu_sel    = (cpu_hit | ramcr_rd) & ~cpu_hold_q;

`ifdef IRAM_RAMCR_EN
  logic          rame_q, rame_d;
  logic          stby_q, stby_d;
  logic          ramcr_wr;
  logic [DW-1:0] ramcr_val;

  assign ramcr_wr = cpu_vma & ~cpu_rw & (cpu_addr == RAMCR_ADDR);
  assign ramcr_rd = cpu_vma &  cpu_rw & (cpu_addr == RAMCR_ADDR);
  assign rame     = rame_q;

  // RAMCR next value: RAME follows writes, STBY can only be cleared.
  always_comb begin
    rame_d = rame_q;
    stby_d = stby_q;
    if (ramcr_wr) begin
      rame_d = cpu_wdata[RAMCR_RAME_BIT];
      stby_d = stby_q & cpu_wdata[RAMCR_STBY_BIT];
    end
  end

  // RAMCR register; both bits come out of reset set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rame_q <= 1'b1;
      stby_q <= 1'b1;
    end else begin
      rame_q <= rame_d;
      stby_q <= stby_d;
    end
  end

  // Register read view: unused bits read as zero.
  always_comb begin
    ramcr_val                 = '0;
    ramcr_val[RAMCR_RAME_BIT] = rame_q;
    ramcr_val[RAMCR_STBY_BIT] = stby_q;
  end

  assign cpu_rdata = ramcr_rd ? ramcr_val : ram_rdata;
`else
  assign ramcr_rd  = 1'b0;
  assign rame      = 1'b1;
  assign cpu_rdata = ram_rdata;
`endif

  // Arbitration: next state, starvation counter and DMA completion capture.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dma_ack_d   = 1'b0;
    dma_rdata_d = dma_rdata_q;
    dma_own     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dma_req && !cpu_hit) begin
          dma_own = 1'b1;
        end else if (dma_req) begin
          // Blocked by the CPU: count, and force a hold once starved.
          if (wait_cnt_q == WAIT_LAST) begin
            state_d    = HOLD_REQ;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          wait_cnt_d = '0;
        end
      end
      HOLD_REQ: begin
        // Port stays with the CPU so its in-flight access completes.
        if (dma_req) begin
          state_d = HOLD_GNT;
        end else begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end
      end
      HOLD_GNT: begin
        dma_own = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
    if (dma_own) begin
      dma_ack_d   = 1'b1;
      dma_rdata_d = ram_rdata;
      wait_cnt_d  = '0;
    end
    cpu_hold_d = (state_d != IDLE);
  end

  // While reset is asserted the port is always driven from the CPU side.
  assign dma_port = dma_own & rst_n;

  // RAM port mux; a CPU write is masked whenever the DMA owns the port.
  always_comb begin
    if (dma_port) begin
      ram_addr  = dma_addr;
      ram_we    = ~dma_rw;
      ram_wdata = dma_wdata;
    end else begin
      ram_addr  = cpu_addr[AW-1:0];
      ram_we    = cpu_hit & ~cpu_rw;
      ram_wdata = cpu_wdata;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      cpu_hold_q  <= 1'b0;
      dma_ack_q   <= 1'b0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      cpu_hold_q  <= cpu_hold_d;
      dma_ack_q   <= dma_ack_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign cpu_hold  = cpu_hold_q;
  assign dma_ack   = dma_ack_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: doc/iram_arbiter.md
Name: iram_arbiter

Overview:
- Shares the 128x8 on-chip RAM (CPU window 0x0080-0x00FF) between the cpu01 bus and a DMA/debug requester with a req/ack handshake.
- The CPU has default priority with zero added latency.
- A DMA request starved for MAX_WAIT cycles forces a CPU hold and takes one RAM slot.
- Sits between the MC6803 top-level bus decode and the RAM array.

Parameters:
- AW, 7, RAM address width (128 bytes).
- DW, 8, data width.
- MAX_WAIT, 8, consecutive blocked DMA cycles before the CPU is held; legal range 1..255.
- IRAM_BASE, 16'h0080, CPU address of RAM byte 0.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_vma  in  1  CPU valid memory address.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  read data to the CPU data_in mux.
- cpu_sel  out  1  arbiter claims this CPU cycle; top level uses cpu_rdata.
- cpu_hold  out  1  registered hold to cpu01.
- dma_req  in  1  level request, held until dma_ack.
- dma_rw  in  1  1 = read, 0 = write.
- dma_addr  in  AW  RAM byte address.
- dma_wdata  in  DW  write data.
- dma_ack  out  1  one-cycle registered completion pulse.
- dma_rdata  out  DW  registered read data, valid while dma_ack = 1.
- ram_addr  out  AW  RAM port address.
- ram_we  out  1  RAM write enable (write on posedge).
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM asynchronous read data.

Behaviour:
- Reset (async, rst_n = 0): state IDLE, wait_cnt 0, cpu_hold 0, dma_ack 0, dma_rdata 0. Combinational outputs are driven from the CPU side.
- cpu_hit = cpu_vma & (cpu_addr >= IRAM_BASE) & (cpu_addr < IRAM_BASE+128). cpu_sel = cpu_hit & ~cpu_hold.
- CPU path: when the port belongs to the CPU, ram_addr = cpu_addr[6:0], ram_wdata = cpu_wdata, ram_we = cpu_hit & ~cpu_rw, cpu_rdata = ram_rdata. No added latency.
- IDLE:
  - If dma_req & ~cpu_hit, the port goes to DMA this cycle: ram_addr = dma_addr, ram_we = ~dma_rw. On that edge: dma_ack <= 1, dma_rdata <= ram_rdata, wait_cnt <= 0.
  - If dma_req & cpu_hit: wait_cnt++. When wait_cnt == MAX_WAIT-1 and still blocked, go to HOLD_REQ.
  - If ~dma_req: wait_cnt <= 0.
- HOLD_REQ (one cycle):
  - cpu_hold = 1; port stays with the CPU so the in-flight CPU access completes, writes included.
  - Next state HOLD_GNT if dma_req is still 1. Otherwise go to IDLE, release the hold, clear wait_cnt.
- HOLD_GNT (one cycle):
  - cpu_hold = 1; port goes to DMA and the CPU write enable is masked.
  - Edge: dma_ack <= 1, dma_rdata captured, wait_cnt <= 0, next IDLE (cpu_hold <= 0).
- dma_ack is high exactly one cycle per transfer. The requester must drop dma_req or present the next request in the ack cycle.
  - A request still high in the ack cycle is treated as a new transfer.
  - Back-to-back DMA grants in IDLE allowed when ~cpu_hit (one transfer per cycle).
- Simultaneous DMA and CPU write to the same address in IDLE: the CPU wins, DMA waits.
- MAX_WAIT = 1: a blocked request enters HOLD_REQ on the first blocked cycle.
- Reset mid-transfer (any state): immediate return to IDLE. No ack is issued and the transfer is lost.

Optional Feature:
- Macro IRAM_RAMCR_EN.
- Defined:
  - Adds the RAM control register at CPU address 0x0014. Bit6 = RAME (reset 1), bit7 = STBY (reset 1, write 0 only); other bits read 0.
  - CPU reads of 0x0014 assert cpu_sel and return the register.
  - When RAME = 0, cpu_hit is forced to 0: the window falls through to external memory. DMA access is unaffected.
- Not defined: no register; 0x0014 is not claimed; RAME is treated as constant 1.

Decomposition:
- Package iram_arb_pkg holds:
  - state enum {IDLE, HOLD_REQ, HOLD_GNT};
  - IRAM_SIZE = 128;
  - RAMCR_ADDR = 16'h0014;
  - RAMCR bit-index constants.
- No sub-module: the RAM array is instantiated outside; the arbiter is a single module.

Test Plan:
- DMA read 0x05 with cpu_vma = 0, RAM[5] = 0xA5 -> dma_ack one cycle later, dma_rdata = 0xA5, cpu_hold stays 0.
- CPU write 0x0090 = 0x3C while dma_req write 0x10 = 0x77 -> CPU wins (RAM[0x10] = 0x3C). DMA is acked on the first non-hit cycle and RAM[0x10] = 0x77.
- CPU hitting the window every cycle, DMA read pending, MAX_WAIT = 8 -> HOLD_REQ after 8 blocked cycles, cpu_hold high for 2 cycles, dma_ack in the cycle after HOLD_GNT.
- dma_req dropped while in HOLD_REQ -> next state IDLE, cpu_hold low, no dma_ack.
- rst_n asserted during HOLD_GNT -> cpu_hold and dma_ack go 0 asynchronously, state IDLE, RAM unchanged by the DMA write.
- With IRAM_RAMCR_EN: write 0x00 to 0x0014, read 0x0085 -> cpu_sel = 0. Read 0x0014 -> 0x00. DMA write 0x05 still succeeds.
